neuron_compute_unit: RTL and testbench

//  Downstream consumer of the per-neuron parameter store. Integrates one axon spike frame into
//  one neuron: serial weighted accumulation over all axons, then leak, threshold test and reset.

---
 rtl/snn_pkg.sv | 42 ++++
 rtl/snn_sat_add.sv | 17 +
 rtl/neuron_compute_unit.sv | 199 +++++++++++++++++++
 tb/tb_neuron_compute_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron compute path: FSM encoding,
// reset-mode codes, default widths and a width-generic signed clamp.
package snn_pkg;

    localparam int NUM_AXONS_DEF       = 256;
    localparam int LEAK_WIDTH_DEF      = 9;
    localparam int WEIGHT_WIDTH_DEF    = 2;
    localparam int THRESHOLD_WIDTH_DEF = 9;
    localparam int POTENTIAL_WIDTH_DEF = 9;
    localparam int NUM_RESET_MODES_DEF = 2;

    localparam int RESET_MODE_ABSOLUTE = 0;
    localparam int RESET_MODE_LINEAR   = 1;

    // Widest operand the clamp helper accepts.
    localparam int SAT_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_INTEG     = 2'd1,
        ST_LEAK_FIRE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // Clamp a sign-extended value into the signed range of a w-bit word.
    function automatic logic signed [SAT_MAX_W:0] sat_clamp(
        input logic signed [SAT_MAX_W:0] x,
        input int                        w
    );
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        hi = ((SAT_MAX_W+1)'(1) <<< (w - 1)) - (SAT_MAX_W+1)'(1);
        lo = ~hi;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/snn_sat_add.sv
// Signed N-bit adder whose result clamps to the N-bit range instead of wrapping.
module snn_sat_add
    import snn_pkg::*;
#(
    parameter int N = 9
) (
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic signed [N-1:0] y
);

    logic signed [N:0] sum;

    assign sum = (N+1)'(a) + (N+1)'(b);
    assign y   = N'(sat_clamp((SAT_MAX_W+1)'(sum), N));

endmodule

// File: rtl/neuron_compute_unit.sv
// Integrates one axon spike frame into one neuron: serial saturating accumulation,
// then leak, threshold test and reset, with results held until the next frame.
module neuron_compute_unit
    import snn_pkg::*;
#(
    parameter int NUM_AXONS       = NUM_AXONS_DEF,
    parameter int LEAK_WIDTH      = LEAK_WIDTH_DEF,
    parameter int WEIGHT_WIDTH    = WEIGHT_WIDTH_DEF,
    parameter int THRESHOLD_WIDTH = THRESHOLD_WIDTH_DEF,
    parameter int POTENTIAL_WIDTH = POTENTIAL_WIDTH_DEF,
    parameter int NUM_RESET_MODES = NUM_RESET_MODES_DEF,
    localparam int RM_W = (NUM_RESET_MODES > 1) ? $clog2(NUM_RESET_MODES) : 1
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    input  logic                              start_i,
    input  logic [NUM_AXONS-1:0]              axon_spikes_i,
    input  logic [NUM_AXONS-1:0]              axon_type_i,
    input  logic [NUM_AXONS-1:0]              connections_i,
    input  logic signed [LEAK_WIDTH-1:0]      leak_i,
    input  logic signed [WEIGHT_WIDTH-1:0]    weights_0_i,
    input  logic signed [WEIGHT_WIDTH-1:0]    weights_1_i,
    input  logic signed [THRESHOLD_WIDTH-1:0] positive_threshold_i,
    input  logic signed [THRESHOLD_WIDTH-1:0] negative_threshold_i,
    input  logic signed [POTENTIAL_WIDTH-1:0] reset_potential_i,
    input  logic signed [POTENTIAL_WIDTH-1:0] current_potential_i,
    input  logic [RM_W-1:0]                   reset_mode_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              spike_o,
    output logic signed [POTENTIAL_WIDTH-1:0] potential_o
);

    localparam int P     = POTENTIAL_WIDTH;
    localparam int IDX_W = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;

    state_t                        state_reg, state_next;
    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic signed [P-1:0]           acc_reg, acc_next;
    logic                          spike_reg, spike_next;
    logic signed [P-1:0]           potential_reg, potential_next;

    logic [NUM_AXONS-1:0]          spikes_reg;
    logic [NUM_AXONS-1:0]          type_reg;
    logic [NUM_AXONS-1:0]          conn_reg;
    logic signed [LEAK_WIDTH-1:0]  leak_reg;
    logic signed [WEIGHT_WIDTH-1:0] w0_reg;
    logic signed [WEIGHT_WIDTH-1:0] w1_reg;
    logic signed [THRESHOLD_WIDTH-1:0] pos_th_reg;
    logic signed [THRESHOLD_WIDTH-1:0] neg_th_reg;
    logic signed [P-1:0]           rst_pot_reg;
    logic [RM_W-1:0]               mode_reg;

    logic                          start_accept;
    logic [NUM_AXONS-1:0]          active_vec;
    logic signed [P-1:0]           weight_ext;
    logic signed [P-1:0]           leak_ext;
    logic signed [P-1:0]           integ_sum;
    logic signed [P-1:0]           leaked;
    logic signed [P:0]             p_ext;
    logic signed [P:0]             pos_ext;
    logic signed [P:0]             neg_ext;
    logic signed [P:0]             over_diff;
    logic                          mode_linear;
    logic                          fire_spike;
    logic signed [P-1:0]           fire_pot;

    assign start_accept = (state_reg == ST_IDLE) && start_i;

    generate
        for (genvar gi = 0; gi < NUM_AXONS; gi++) begin : g_active
            assign active_vec[gi] = spikes_reg[gi] & conn_reg[gi];
        end
    endgenerate

    assign weight_ext = type_reg[idx_reg] ? P'(w1_reg) : P'(w0_reg);
    assign leak_ext   = P'(leak_reg);

    snn_sat_add #(.N(P)) u_integ_add (
        .a (acc_reg),
        .b (weight_ext),
        .y (integ_sum)
    );

    snn_sat_add #(.N(P)) u_leak_add (
        .a (acc_reg),
        .b (leak_ext),
        .y (leaked)
    );

    // Out-of-range mode codes fall back to absolute reset.
    assign mode_linear = (NUM_RESET_MODES > RESET_MODE_LINEAR) &&
                         (mode_reg == RM_W'(RESET_MODE_LINEAR));

    assign p_ext     = (P+1)'(leaked);
    assign pos_ext   = (P+1)'(pos_th_reg);
    assign neg_ext   = (P+1)'(neg_th_reg);
    assign over_diff = p_ext - pos_ext;

    always_comb begin
        fire_spike = 1'b0;
        fire_pot   = leaked;
        if (p_ext >= pos_ext) begin
            fire_spike = 1'b1;
            fire_pot   = mode_linear ? P'(sat_clamp((SAT_MAX_W+1)'(over_diff), P)) : rst_pot_reg;
        end else if (p_ext < neg_ext) begin
            fire_pot   = mode_linear ? P'(neg_th_reg) : rst_pot_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        acc_next       = acc_reg;
        spike_next     = spike_reg;
        potential_next = potential_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    state_next     = ST_INTEG;
                    idx_next       = '0;
                    acc_next       = current_potential_i;
                    spike_next     = 1'b0;
                    potential_next = '0;
                end
            end
            ST_INTEG: begin
                if (active_vec[idx_reg])
                    acc_next = integ_sum;
                if (idx_reg == IDX_W'(NUM_AXONS - 1)) begin
                    state_next = ST_LEAK_FIRE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_LEAK_FIRE: begin
                state_next     = ST_DONE;
                spike_next     = fire_spike;
                potential_next = fire_pot;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            acc_reg       <= '0;
            spike_reg     <= 1'b0;
            potential_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            acc_reg       <= acc_next;
            spike_reg     <= spike_next;
            potential_reg <= potential_next;
        end
    end

    // Frame snapshot: the store may change its outputs while a frame is in flight.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            spikes_reg  <= '0;
            type_reg    <= '0;
            conn_reg    <= '0;
            leak_reg    <= '0;
            w0_reg      <= '0;
            w1_reg      <= '0;
            pos_th_reg  <= '0;
            neg_th_reg  <= '0;
            rst_pot_reg <= '0;
            mode_reg    <= '0;
        end else if (start_accept) begin
            spikes_reg  <= axon_spikes_i;
            type_reg    <= axon_type_i;
            conn_reg    <= connections_i;
            leak_reg    <= leak_i;
            w0_reg      <= weights_0_i;
            w1_reg      <= weights_1_i;
            pos_th_reg  <= positive_threshold_i;
            neg_th_reg  <= negative_threshold_i;
            rst_pot_reg <= reset_potential_i;
            mode_reg    <= reset_mode_i;
        end
    end

    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = (state_reg == ST_DONE);
    assign spike_o     = spike_reg;
    assign potential_o = potential_reg;

endmodule

// File: tb/tb_neuron_compute_unit.sv
// Directed bench for neuron_compute_unit: saturation, weighting, fire/floor modes,
// start-ignore behaviour and asynchronous abort.
module tb_neuron_compute_unit;

    localparam int NA  = 256;
    // Start cycle is T; done_o occupies T+NA+2, i.e. NA+1 edges after the accept edge.
    localparam int LAT = NA + 1;

    logic                clk;
    logic                rst_n;
    logic                start_i;
    logic [NA-1:0]       axon_spikes_i;
    logic [NA-1:0]       axon_type_i;
    logic [NA-1:0]       connections_i;
    logic signed [8:0]   leak_i;
    logic signed [1:0]   weights_0_i;
    logic signed [1:0]   weights_1_i;
    logic signed [8:0]   positive_threshold_i;
    logic signed [8:0]   negative_threshold_i;
    logic signed [8:0]   reset_potential_i;
    logic signed [8:0]   current_potential_i;
    logic [0:0]          reset_mode_i;
    logic                busy_o;
    logic                done_o;
    logic                spike_o;
    logic signed [8:0]   potential_o;

    int errors = 0;
    int checks = 0;

    neuron_compute_unit dut (
        .wb_clk_i             (clk),
        .wb_rst_ni            (rst_n),
        .start_i              (start_i),
        .axon_spikes_i        (axon_spikes_i),
        .axon_type_i          (axon_type_i),
        .connections_i        (connections_i),
        .leak_i               (leak_i),
        .weights_0_i          (weights_0_i),
        .weights_1_i          (weights_1_i),
        .positive_threshold_i (positive_threshold_i),
        .negative_threshold_i (negative_threshold_i),
        .reset_potential_i    (reset_potential_i),
        .current_potential_i  (current_potential_i),
        .reset_mode_i         (reset_mode_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .spike_o              (spike_o),
        .potential_o          (potential_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        axon_spikes_i        = '0;
        axon_type_i          = '0;
        connections_i        = '0;
        leak_i               = 9'sd0;
        weights_0_i          = 2'sd0;
        weights_1_i          = 2'sd0;
        positive_threshold_i = 9'sd255;
        negative_threshold_i = -9'sd256;
        reset_potential_i    = 9'sd0;
        current_potential_i  = 9'sd0;
        reset_mode_i         = 1'b0;
    endtask

    // Pulses start, then returns the number of edges after the accept edge until
    // done_o is seen (-1 on timeout). Leaves the caller in the DONE cycle.
    task automatic run_frame(output int lat);
        lat = -1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (done_o) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_o, done_o, spike_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/spike=%b expected 000", {busy_o, done_o, spike_o});
        end
        checks++;
        if (potential_o !== 9'sd0) begin
            errors++;
            $display("FAIL reset_potential: got %0d expected 0", potential_o);
        end
        $display("reset: busy=%b done=%b spike=%b pot=%0d", busy_o, done_o, spike_o, potential_o);
    endtask

    task automatic test_saturate();
        int lat;
        clear_inputs();
        axon_spikes_i = '1;
        connections_i = '1;
        weights_0_i   = 2'sd1;
        run_frame(lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL sat_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (spike_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_spike: got %b expected 1", spike_o);
        end
        checks++;
        if (potential_o !== 9'sd0) begin
            errors++;
            $display("FAIL sat_potential: got %0d expected 0", potential_o);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL sat_busy_in_done: got %b expected 1", busy_o);
        end
        @(negedge clk);
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL sat_done_pulse: done/busy=%b expected 00", {done_o, busy_o});
        end
        $display("frame saturate: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
    endtask

    task automatic test_weighted();
        int lat;
        clear_inputs();
        axon_spikes_i[3]     = 1'b1;
        axon_spikes_i[10]    = 1'b1;
        connections_i[3]     = 1'b1;
        connections_i[10]    = 1'b1;
        axon_type_i[10]      = 1'b1;
        weights_0_i          = 2'sd1;
        weights_1_i          = -2'sd2;
        current_potential_i  = 9'sd5;
        leak_i               = -9'sd1;
        positive_threshold_i = 9'sd10;
        // Spike at 20 has no connection and must not count.
        axon_spikes_i[20]    = 1'b1;
        run_frame(lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL weighted_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (spike_o !== 1'b0) begin
            errors++;
            $display("FAIL weighted_spike: got %b expected 0", spike_o);
        end
        checks++;
        if (potential_o !== 9'sd3) begin
            errors++;
            $display("FAIL weighted_potential: got %0d expected 3", potential_o);
        end
        $display("frame weighted: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
    endtask

    task automatic test_fire_modes();
        int lat;
        clear_inputs();
        current_potential_i  = 9'sd8;
        leak_i               = 9'sd3;
        positive_threshold_i = 9'sd10;
        reset_mode_i         = 1'b1;
        run_frame(lat);
        checks++;
        if ({spike_o, potential_o} !== {1'b1, 9'sd1}) begin
            errors++;
            $display("FAIL fire_linear: spike=%b pot=%0d expected spike=1 pot=1", spike_o, potential_o);
        end
        $display("frame fire mode1: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
        reset_mode_i      = 1'b0;
        reset_potential_i = -9'sd4;
        run_frame(lat);
        checks++;
        if ({spike_o, potential_o} !== {1'b1, -9'sd4}) begin
            errors++;
            $display("FAIL fire_absolute: spike=%b pot=%0d expected spike=1 pot=-4", spike_o, potential_o);
        end
        $display("frame fire mode0: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
    endtask

    task automatic test_negative_floor();
        int lat;
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            axon_spikes_i[i * 7] = 1'b1;
            connections_i[i * 7] = 1'b1;
        end
        current_potential_i  = -9'sd250;
        weights_0_i          = -2'sd2;
        negative_threshold_i = -9'sd100;
        reset_mode_i         = 1'b1;
        run_frame(lat);
        checks++;
        if ({spike_o, potential_o} !== {1'b0, -9'sd100}) begin
            errors++;
            $display("FAIL floor_linear: spike=%b pot=%0d expected spike=0 pot=-100", spike_o, potential_o);
        end
        $display("frame floor mode1: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
        // Same frame, absolute mode: the saturated -256 is below the floor, load reset value.
        reset_mode_i      = 1'b0;
        reset_potential_i = 9'sd7;
        run_frame(lat);
        checks++;
        if ({spike_o, potential_o} !== {1'b0, 9'sd7}) begin
            errors++;
            $display("FAIL floor_absolute: spike=%b pot=%0d expected spike=0 pot=7", spike_o, potential_o);
        end
        $display("frame floor mode0: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
    endtask

    task automatic test_ignored_start();
        int lat;
        int dones;
        clear_inputs();
        axon_spikes_i[3]     = 1'b1;
        axon_spikes_i[10]    = 1'b1;
        connections_i[3]     = 1'b1;
        connections_i[10]    = 1'b1;
        axon_type_i[10]      = 1'b1;
        weights_0_i          = 2'sd1;
        weights_1_i          = -2'sd2;
        current_potential_i  = 9'sd5;
        leak_i               = -9'sd1;
        positive_threshold_i = 9'sd10;
        lat   = -1;
        dones = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (k == 50) begin
                start_i             = 1'b1;
                axon_spikes_i       = '1;
                connections_i       = '1;
                current_potential_i = 9'sd100;
                leak_i              = 9'sd50;
                reset_mode_i        = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL ignore_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if ({spike_o, potential_o} !== {1'b0, 9'sd3}) begin
            errors++;
            $display("FAIL ignore_result: spike=%b pot=%0d expected spike=0 pot=3", spike_o, potential_o);
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL ignore_done_start: busy=%b expected 0", busy_o);
        end
        for (int k = 0; k < 20; k++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL ignore_extra_done: got %0d extra done pulses expected 0", dones);
        end
        $display("frame ignore-start: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
    endtask

    task automatic test_reset_abort();
        int lat;
        int dones;
        dones = 0;
        clear_inputs();
        axon_spikes_i = '1;
        connections_i = '1;
        weights_0_i   = 2'sd1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, spike_o} !== 3'b000 || potential_o !== 9'sd0) begin
            errors++;
            $display("FAIL abort_outputs: busy/done/spike=%b pot=%0d expected 000 pot=0",
                     {busy_o, done_o, spike_o}, potential_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (done_o) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", dones);
        end
        clear_inputs();
        axon_spikes_i[3]     = 1'b1;
        connections_i[3]     = 1'b1;
        weights_0_i          = 2'sd1;
        current_potential_i  = 9'sd5;
        leak_i               = -9'sd1;
        positive_threshold_i = 9'sd10;
        run_frame(lat);
        checks++;
        if (lat !== LAT || {spike_o, potential_o} !== {1'b0, 9'sd5}) begin
            errors++;
            $display("FAIL abort_recover: lat=%0d spike=%b pot=%0d expected lat=%0d spike=0 pot=5",
                     lat, spike_o, potential_o, LAT);
        end
        $display("frame after abort: lat=%0d spike=%b pot=%0d", lat, spike_o, potential_o);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_saturate();
        test_weighted();
        test_fire_modes();
        test_reset_abort();
        test_negative_floor();
        test_ignored_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
